spi_mem_arbiter: RTL and testbench
==================================

// Module: spi_mem_arbiter
// PURPOSE
//  Round-robin arbiter sharing one SPI memory master between NUM_REQ requesters.
//  Latches the winner's {addr, wr_data, wr} and issues a single-cycle tr_start to the master.
//  Waits for the master's tr_done, then returns read data and error status to the granted requester.
//  Sits between the client logic and the SPI master; the master's SPI pins are not touched here.
// PARAMETERS
//  NUM_REQ      4     number of requesters (2..8)
//  ADDR_W       8     address width, matches the master
//  DATA_W       8     data width, matches the master
//  TIMEOUT_CYC  1024  WAIT-state watchdog limit in clk cycles (used only with SPI_ARB_TIMEOUT_EN)
// PORTS
//  clk            in   1                 clock
//  rst_n          in   1                 reset, asynchronous, active-low
//  req_valid      in   NUM_REQ           per-requester request; held high until that requester's req_done
//  req_addr       in   NUM_REQ*ADDR_W    packed addresses; slice i = [i*ADDR_W +: ADDR_W]
//  req_wdata      in   NUM_REQ*DATA_W    packed write data
//  req_wr         in   NUM_REQ           1 = write, 0 = read
//  req_grant      out  NUM_REQ           one-hot; current owner, held from ISSUE through RESP
//  req_done       out  NUM_REQ           one-cycle completion pulse to the owner
//  rsp_rdata      out  DATA_W            read data; valid while req_done is high
//  rsp_err        out  1                 error flag; valid while req_done is high
//  busy           out  1                 high in every state other than IDLE
//  ctrl_addr      out  ADDR_W            to master addr
//  ctrl_wdata     out  DATA_W            to master wr_data
//  ctrl_wr        out  1                 to master wr
//  ctrl_tr_start  out  1                 to master tr_start; one-cycle pulse
//  ctrl_tr_done   in   1                 from master tr_done
//  ctrl_rdata     in   DATA_W            from master read_data
//  ctrl_spi_err   in   1                 from master spi_err
// BEHAVIOUR
//  Reset:
//   - All outputs are 0, FSM is in IDLE, last_grant = NUM_REQ-1, so requester 0 wins first.
//   - Reset mid-transaction abandons the transfer; no req_done is issued.
//  FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
//  IDLE:
//   - If any req_valid is high, pick the first set bit scanning from (last_grant+1) mod NUM_REQ upward, wrapping.
//   - Latch that requester's addr/wdata/wr into ctrl_*; set req_grant; set ctrl_tr_start <= 1; go to ISSUE.
//  ISSUE:
//   - ctrl_tr_start is high for exactly this one cycle, then cleared; go to WAIT.
//  WAIT:
//   - On ctrl_tr_done = 1: capture rsp_rdata <= ctrl_rdata and rsp_err <= ctrl_spi_err.
//   - In the same edge set req_done[owner] <= 1, then go to RESP.
//   - ctrl_spi_err is sampled only on the tr_done cycle; its value at any other time is ignored.
//  RESP:
//   - req_done is high for one cycle; last_grant <= owner.
//   - At the next edge: clear req_grant, req_done, rsp_rdata, rsp_err; go to IDLE.
//  Latency and throughput:
//   - req_valid sampled at edge k -> ctrl_tr_start high in cycle k+1.
//   - ctrl_tr_done sampled at edge m -> req_done high in cycle m+1.
//   - Minimum spacing between successive tr_start pulses is one IDLE cycle after RESP.
//  Fairness: the owner just served has lowest priority next round; no requester starves.
//  ctrl_addr/ctrl_wdata/ctrl_wr:
//   - Stay stable from ISSUE until the next arbitration.
//   - Later changes to req_* of the owner are ignored.
//  req_valid of the owner dropping during WAIT: the transfer completes and req_done still pulses.
//  ctrl_tr_done seen in IDLE/ISSUE/RESP is ignored (stray pulse); no state change.
//  A new request arriving during a transfer waits; it is arbitrated only in IDLE.
// CONFIGURATION
//  SPI_ARB_TIMEOUT_EN defined:
//   - A counter runs in WAIT; it is cleared on entry to WAIT.
//   - If TIMEOUT_CYC cycles pass without ctrl_tr_done, go to RESP with rsp_err = 1 and rsp_rdata = 0.
//   - After a timeout the FSM returns to IDLE normally.
//  SPI_ARB_TIMEOUT_EN undefined:
//   - No counter; WAIT lasts until ctrl_tr_done. TIMEOUT_CYC is unused.
// TESTING
//  1. Single write: only req_valid[1] high, addr 0x05, wdata 0xA5, wr 1
//     -> one tr_start pulse, ctrl_addr 0x05, ctrl_wdata 0xA5, ctrl_wr 1;
//     -> after tr_done, req_done[1] pulses once with rsp_err 0.
//  2. Read: req 0 reads addr 0x10; master returns 0x3C
//     -> rsp_rdata 0x3C and req_done[0] high in the cycle after tr_done.
//  3. Contention: all 4 req_valid held high
//     -> grant order 0,1,2,3,0; exactly one tr_start per grant; never two grants at once.
//  4. Error: master returns tr_done with spi_err 1 (addr 0x40)
//     -> rsp_err 1 on that req_done; the next transfer's rsp_err follows its own tr_done sample.
//  5. Reset in WAIT: assert rst_n low
//     -> all outputs 0; after release, requester 0 is served first.
//  6. With SPI_ARB_TIMEOUT_EN and TIMEOUT_CYC = 16, master never answers
//     -> req_done at WAIT cycle 16 with rsp_err 1 and rsp_rdata 0; arbiter back in IDLE.

Source files
------------

// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: round-robin arbiter that shares one SPI memory master
// between NUM_REQ requesters. The winner's {addr, wr_data, wr} is latched
// onto the master interface, a one-cycle tr_start is issued, and the
// master's read data / error status are returned with a one-cycle req_done.
//
// Optional feature: define SPI_ARB_TIMEOUT_EN to enable a WAIT-state
// watchdog. If the master does not answer within TIMEOUT_CYC cycles, the
// transfer is completed with rsp_err = 1 and rsp_rdata = 0.
module spi_mem_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]        req_wr,
    output logic [NUM_REQ-1:0]        req_grant,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      busy,
    output logic [ADDR_W-1:0]         ctrl_addr,
    output logic [DATA_W-1:0]         ctrl_wdata,
    output logic                      ctrl_wr,
    output logic                      ctrl_tr_start,
    input  logic                      ctrl_tr_done,
    input  logic [DATA_W-1:0]         ctrl_rdata,
    input  logic                      ctrl_spi_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Parameter guard rails, evaluated at elaboration.
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_num_req_chk
        $error("spi_mem_arbiter: NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYC < 2) begin : g_timeout_chk
        $error("spi_mem_arbiter: TIMEOUT_CYC must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] arb_pick;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    logic [CNT_W-1:0] wait_cnt;
`endif

    // First requesting index strictly after 'last', wrapping around. The loop
    // runs from the farthest offset to the nearest so the nearest one wins.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                                 input logic [IDX_W-1:0]   last);
        logic [IDX_W-1:0] pick;
        int               idx;
        pick = last;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = int'(last) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (vld[idx]) begin
                pick = IDX_W'(idx);
            end
        end
        return pick;
    endfunction

    function automatic logic [NUM_REQ-1:0] one_hot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Only meaningful in IDLE when some req_valid bit is set.
    assign arb_pick = rr_pick(req_valid, last_grant);

    // Arbitration / transfer sequencing FSM; every output is a register here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            owner         <= '0;
            last_grant    <= IDX_W'(NUM_REQ - 1);
            req_grant     <= '0;
            req_done      <= '0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
            busy          <= 1'b0;
            ctrl_addr     <= '0;
            ctrl_wdata    <= '0;
            ctrl_wr       <= 1'b0;
            ctrl_tr_start <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            wait_cnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        owner         <= arb_pick;
                        req_grant     <= one_hot(arb_pick);
                        ctrl_addr     <= req_addr[int'(arb_pick)*ADDR_W +: ADDR_W];
                        ctrl_wdata    <= req_wdata[int'(arb_pick)*DATA_W +: DATA_W];
                        ctrl_wr       <= req_wr[arb_pick];
                        ctrl_tr_start <= 1'b1;
                        busy          <= 1'b1;
                        state         <= ISSUE;
                    end
                end

                ISSUE: begin
                    ctrl_tr_start <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
                    wait_cnt      <= '0;
`endif
                    state         <= WAIT;
                end

                WAIT: begin
                    // spi_err is only meaningful on the tr_done cycle.
                    if (ctrl_tr_done) begin
                        rsp_rdata <= ctrl_rdata;
                        rsp_err   <= ctrl_spi_err;
                        req_done  <= one_hot(owner);
                        state     <= RESP;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        req_done  <= one_hot(owner);
                        state     <= RESP;
                    end else begin
                        wait_cnt  <= wait_cnt + CNT_W'(1);
                    end
`endif
                end

                RESP: begin
                    // The owner just served drops to lowest priority.
                    last_grant <= owner;
                    req_grant  <= '0;
                    req_done   <= '0;
                    rsp_rdata  <= '0;
                    rsp_err    <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// tb_spi_mem_arbiter: scoreboard bench for spi_mem_arbiter (default build,
// SPI_ARB_TIMEOUT_EN undefined). A master model answers tr_start after a
// random delay and queues the expected response; a monitor pops the queue on
// req_done and checks arbitration against a round-robin reference.
module tb_spi_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_addr  = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    req_wr    = '0;
    logic [N-1:0]    req_grant;
    logic [N-1:0]    req_done;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            busy;
    logic [AW-1:0]   ctrl_addr;
    logic [DW-1:0]   ctrl_wdata;
    logic            ctrl_wr;
    logic            ctrl_tr_start;
    logic            ctrl_tr_done = 1'b0;
    logic [DW-1:0]   ctrl_rdata   = '0;
    logic            ctrl_spi_err = 1'b0;

    spi_mem_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata), .req_wr(req_wr),
        .req_grant(req_grant), .req_done(req_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata), .ctrl_wr(ctrl_wr),
        .ctrl_tr_start(ctrl_tr_start), .ctrl_tr_done(ctrl_tr_done),
        .ctrl_rdata(ctrl_rdata), .ctrl_spi_err(ctrl_spi_err)
    );

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int unsigned   at;
    } rsp_t;
    rsp_t rsp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- master model ----------------
    int            m_cnt   = 0;
    bit            m_force = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    logic          m_err   = 1'b0;
    bit            stray_en = 1'b0;

    always @(negedge clk) begin
        rsp_t e;
        ctrl_tr_done = 1'b0;
        ctrl_rdata   = DW'($urandom);
        ctrl_spi_err = m_force ? 1'b1 : 1'($urandom);
        if (!rst_n) begin
            m_cnt = 0;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                ctrl_tr_done = 1'b1;
                if (m_force) begin
                    ctrl_rdata   = m_rdata;
                    ctrl_spi_err = m_err;
                end
                e.rdata = ctrl_rdata;
                e.err   = ctrl_spi_err;
                e.at    = cyc + 1;
                rsp_q.push_back(e);
            end
        end else if (ctrl_tr_start) begin
            m_cnt = $urandom_range(1, 6);
        end else if (stray_en && $urandom_range(0, 7) == 0) begin
            ctrl_tr_done = 1'b1;
        end
    end

    // ---------------- reference model + monitor ----------------
    int            last_m   = N - 1;
    int            owner_m  = 0;
    bit            arb_free = 1'b1;
    bit            in_resp  = 1'b0;
    logic [AW-1:0] lat_addr  = '0;
    logic [DW-1:0] lat_wdata = '0;
    logic          lat_wr    = 1'b0;
    int            grant_log[$];
    int            n_done = 0;

    function automatic int rr_ref(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        bit   due;
        rsp_t e;
        int   w;
        #1;
        if (!rst_n) begin
            arb_free  = 1'b1;
            in_resp   = 1'b0;
            last_m    = N - 1;
            lat_addr  = '0;
            lat_wdata = '0;
            lat_wr    = 1'b0;
            rsp_q.delete();
        end else begin
            chk("grant_onehot0", 32'($onehot0(req_grant)), 1);
            due = (rsp_q.size() > 0) && (rsp_q[0].at == cyc);
            if (due) begin
                e = rsp_q.pop_front();
                n_done++;
                chk("req_done", req_done, 32'(1) << owner_m);
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", rsp_err, e.err);
            end else begin
                chk("req_done_quiet", req_done, 0);
                chk("rsp_rdata_quiet", rsp_rdata, 0);
                chk("rsp_err_quiet", rsp_err, 0);
            end
            if (in_resp) begin
                chk("busy_after_resp", busy, 0);
                chk("grant_after_resp", req_grant, 0);
                chk("tr_start_after_resp", ctrl_tr_start, 0);
                last_m   = owner_m;
                arb_free = 1'b1;
                in_resp  = 1'b0;
            end else if (arb_free) begin
                w = rr_ref(req_valid, last_m);
                chk("tr_start_arb", ctrl_tr_start, (w >= 0) ? 1 : 0);
                chk("busy_arb", busy, (w >= 0) ? 1 : 0);
                chk("grant_arb", req_grant, (w >= 0) ? (32'(1) << w) : 0);
                if (w >= 0) begin
                    owner_m   = w;
                    lat_addr  = req_addr[w*AW +: AW];
                    lat_wdata = req_wdata[w*DW +: DW];
                    lat_wr    = req_wr[w];
                    arb_free  = 1'b0;
                    grant_log.push_back(w);
                end
            end else begin
                chk("tr_start_single", ctrl_tr_start, 0);
                chk("busy_xfer", busy, 1);
                chk("grant_held", req_grant, 32'(1) << owner_m);
            end
            chk("ctrl_addr", ctrl_addr, lat_addr);
            chk("ctrl_wdata", ctrl_wdata, lat_wdata);
            chk("ctrl_wr", ctrl_wr, lat_wr);
            if (due) in_resp = 1'b1;
        end
    end

    // ---------------- requester stimulus ----------------
    bit pend[N];

    task automatic step_req(input int raise_pct, input bit mutate, input bit drop);
        for (int i = 0; i < N; i++) begin
            if (req_done[i]) begin
                req_valid[i] = 1'b0;
                pend[i]      = 1'b0;
            end else if (!pend[i]) begin
                if ($urandom_range(1, 100) <= raise_pct) begin
                    pend[i]              = 1'b1;
                    req_valid[i]         = 1'b1;
                    req_addr[i*AW +: AW]  = AW'($urandom);
                    req_wdata[i*DW +: DW] = DW'($urandom);
                    req_wr[i]            = 1'($urandom);
                end
            end else begin
                if (mutate && $urandom_range(0, 3) == 0) begin
                    req_addr[i*AW +: AW]  = AW'($urandom);
                    req_wdata[i*DW +: DW] = DW'($urandom);
                    req_wr[i]            = 1'($urandom);
                end
                if (drop && req_grant[i] && req_valid[i] && $urandom_range(0, 15) == 0)
                    req_valid[i] = 1'b0;
            end
        end
    endtask

    function automatic bit any_pend();
        for (int i = 0; i < N; i++) if (pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain();
        for (int t = 0; t < 400 && any_pend(); t++) begin
            @(negedge clk);
            step_req(0, 0, 0);
        end
        chk("drain_complete", 32'(any_pend()), 0);
    endtask

    task automatic directed(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic w, input logic [DW-1:0] rd, input logic er,
                            input string tag);
        logic [DW-1:0] cap_rd;
        logic          cap_err;
        cap_rd  = '1;
        cap_err = 1'bx;
        m_force = 1'b1;
        m_rdata = rd;
        m_err   = er;
        @(negedge clk);
        step_req(0, 0, 0);
        pend[i]              = 1'b1;
        req_valid[i]         = 1'b1;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req_wr[i]            = w;
        for (int t = 0; t < 100 && pend[i]; t++) begin
            @(negedge clk);
            if (req_done[i]) begin
                cap_rd  = rsp_rdata;
                cap_err = rsp_err;
            end
            step_req(0, 0, 0);
        end
        chk({tag, "_done"}, 32'(pend[i]), 0);
        chk({tag, "_rdata"}, cap_rd, rd);
        chk({tag, "_err"}, cap_err, er);
        chk({tag, "_ctrl_addr"}, ctrl_addr, a);
        chk({tag, "_ctrl_wdata"}, ctrl_wdata, d);
        chk({tag, "_ctrl_wr"}, ctrl_wr, w);
        m_force = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_grant"}, req_grant, 0);
        chk({tag, "_done"}, req_done, 0);
        chk({tag, "_rdata"}, rsp_rdata, 0);
        chk({tag, "_err"}, rsp_err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_addr"}, ctrl_addr, 0);
        chk({tag, "_wdata"}, ctrl_wdata, 0);
        chk({tag, "_wr"}, ctrl_wr, 0);
        chk({tag, "_start"}, ctrl_tr_start, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[5];
        bit found;
        order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) pend[i] = 1'b0;

        // Power-on reset
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        stray_en = 1'b1;

        // Contention: all four held high -> 0,1,2,3,0
        grant_log.delete();
        for (int t = 0; t < 300 && grant_log.size() < 5; t++) begin
            @(negedge clk);
            step_req(100, 0, 0);
        end
        chk("contention_grants", grant_log.size() >= 5, 1);
        for (int k = 0; k < 5 && k < grant_log.size(); k++)
            chk("contention_order", grant_log[k], order[k]);
        drain();

        // Directed single transfers
        directed(1, 8'h05, 8'hA5, 1'b1, 8'h5A, 1'b0, "single_write");
        directed(0, 8'h10, 8'h00, 1'b0, 8'h3C, 1'b0, "read");
        directed(2, 8'h40, 8'h11, 1'b0, 8'h77, 1'b1, "err_set");
        directed(3, 8'h41, 8'h22, 1'b0, 8'h78, 1'b0, "err_next");

        // Randomised traffic with mutation and owner drop
        repeat (1500) begin
            @(negedge clk);
            step_req(30, 1, 1);
        end

        // Reset while a transfer is in WAIT
        found = 1'b0;
        for (int t = 0; t < 300 && !found; t++) begin
            @(negedge clk);
            step_req(30, 1, 1);
            #2;
            if (m_cnt >= 2) found = 1'b1;
        end
        chk("reached_wait", 32'(found), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_in_wait");
        for (int i = 0; i < N; i++) begin
            pend[i]      = 1'b0;
            req_valid[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        grant_log.delete();
        for (int t = 0; t < 100 && grant_log.size() < 1; t++) begin
            @(negedge clk);
            step_req(100, 0, 0);
        end
        chk("post_reset_grants", grant_log.size() >= 1, 1);
        if (grant_log.size() >= 1) chk("post_reset_first", grant_log[0], 0);

        repeat (500) begin
            @(negedge clk);
            step_req(40, 1, 1);
        end
        drain();
        repeat (5) @(negedge clk);
        chk("rsp_queue_empty", rsp_q.size(), 0);
        chk("enough_transfers", n_done > 20, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
